// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the integer register file. The pipeline writeback
// always wins. The mul/div unit and the load-return path share the remaining
// slots under a round-robin pointer. The register-file write is registered one
// cycle after the grant. A starvation counter raises stall_pipe so that a side
// unit cannot be locked out forever by a busy pipeline.
module rf_wb_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_wen,
  input  logic [4:0]      p_waddr,
  input  logic [XLEN-1:0] p_wdata,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [4:0]      m_waddr,
  input  logic [XLEN-1:0] m_wdata,
  input  logic            l_valid,
  output logic            l_ready,
  input  logic [4:0]      l_waddr,
  input  logic [XLEN-1:0] l_wdata,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            stall_pipe,
  output logic            proto_err
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic            rr_q, rr_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            proto_err_q, proto_err_d;
  logic            m_grant, l_grant;

  // Grant decode. Side grants are suppressed while rst is high, so no request
  // is acknowledged during reset.
  always_comb begin
    m_grant = 1'b0;
    l_grant = 1'b0;
    if (!rst && !p_wen) begin
      m_grant = m_valid && (!l_valid || !rr_q);
      l_grant = l_valid && (!m_valid || rr_q);
    end
  end

  assign m_ready    = m_grant;
  assign l_ready    = l_grant;
  assign stall_pipe = (wait_cnt_q == CntMax);
  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign proto_err  = proto_err_q;

  // Next-state logic: write stage, round-robin pointer, starvation counter, error flag.
  always_comb begin
    rr_d        = rr_q;
    wait_cnt_d  = wait_cnt_q;
    rf_wen_d    = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    proto_err_d = proto_err_q | (p_wen & stall_pipe);

    if (p_wen) begin
      rf_wen_d   = (p_waddr != 5'd0);
      rf_waddr_d = p_waddr;
      rf_wdata_d = p_wdata;
    end else if (m_grant) begin
      rf_wen_d   = (m_waddr != 5'd0);
      rf_waddr_d = m_waddr;
      rf_wdata_d = m_wdata;
      rr_d       = 1'b1;
    end else if (l_grant) begin
      rf_wen_d   = (l_waddr != 5'd0);
      rf_waddr_d = l_waddr;
      rf_wdata_d = l_wdata;
      rr_d       = 1'b0;
    end

    if (m_grant || l_grant || !(m_valid || l_valid)) begin
      wait_cnt_d = '0;
    end else if (p_wen && wait_cnt_q != CntMax) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= 1'b0;
      wait_cnt_q  <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      wait_cnt_q  <= wait_cnt_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later, away from the edge.
module tb_rf_wb_arbiter;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            p_wen;
  logic [4:0]      p_waddr;
  logic [XLEN-1:0] p_wdata;
  logic            m_valid, m_ready;
  logic [4:0]      m_waddr;
  logic [XLEN-1:0] m_wdata;
  logic            l_valid, l_ready;
  logic [4:0]      l_waddr;
  logic [XLEN-1:0] l_wdata;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            stall_pipe, proto_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rf_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_wen      (p_wen),
    .p_waddr    (p_waddr),
    .p_wdata    (p_wdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_waddr    (m_waddr),
    .m_wdata    (m_wdata),
    .l_valid    (l_valid),
    .l_ready    (l_ready),
    .l_waddr    (l_waddr),
    .l_wdata    (l_wdata),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_pipe (stall_pipe),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p_wen = 1'b0; p_waddr = '0; p_wdata = '0;
    m_valid = 1'b0; m_waddr = '0; m_wdata = '0;
    l_valid = 1'b0; l_waddr = '0; l_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    total_cnt++;
    if ({rf_wen, rf_waddr, rf_wdata, stall_pipe, proto_err} !== '0)
      $display("FAIL reset_outputs: got wen=%0b addr=%0d data=%0h stall=%0b err=%0b, want all 0",
               rf_wen, rf_waddr, rf_wdata, stall_pipe, proto_err);
    else pass_cnt++;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_pipeline();
    do_reset();
    p_wen = 1'b1; p_waddr = 5'd5; p_wdata = 64'hDEAD;
    m_valid = 1'b1; m_waddr = 5'd3; l_valid = 1'b1; l_waddr = 5'd4;
    #1;
    total_cnt++;
    if (m_ready !== 1'b0 || l_ready !== 1'b0)
      $display("FAIL pipe_readies: got m=%0b l=%0b, want 0 0", m_ready, l_ready);
    else pass_cnt++;
    step();
    idle_inputs();
    total_cnt++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'hDEAD)
      $display("FAIL pipe_write: got wen=%0b addr=%0d data=%0h, want 1 5 dead",
               rf_wen, rf_waddr, rf_wdata);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 64'hDEAD)
      $display("FAIL pipe_idle_hold: got wen=%0b addr=%0d data=%0h, want 0 5 dead",
               rf_wen, rf_waddr, rf_wdata);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    m_valid = 1'b1; m_waddr = 5'd3; m_wdata = 64'h33;
    l_valid = 1'b1; l_waddr = 5'd4; l_wdata = 64'h44;
    for (int k = 0; k < 4; k++) begin
      #1;
      total_cnt++;
      if (m_ready !== (k % 2 == 0) || l_ready !== (k % 2 == 1))
        $display("FAIL rr_grant%0d: got m=%0b l=%0b, want m=%0b l=%0b",
                 k, m_ready, l_ready, (k % 2 == 0), (k % 2 == 1));
      else pass_cnt++;
      step();
      total_cnt++;
      if (rf_wen !== 1'b1 || rf_waddr !== ((k % 2 == 0) ? 5'd3 : 5'd4) ||
          rf_wdata !== ((k % 2 == 0) ? 64'h33 : 64'h44))
        $display("FAIL rr_write%0d: got wen=%0b addr=%0d data=%0h, want 1 %0d",
                 k, rf_wen, rf_waddr, rf_wdata, (k % 2 == 0) ? 3 : 4);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  // Leaves the bench in the first cycle where stall_pipe should be high.
  task automatic starve_m();
    p_wen = 1'b1; p_waddr = 5'd1; p_wdata = 64'h11;
    m_valid = 1'b1; m_waddr = 5'd9; m_wdata = 64'h99;
    for (int k = 0; k < 4; k++) begin
      #1;
      total_cnt++;
      if (stall_pipe !== 1'b0 || m_ready !== 1'b0)
        $display("FAIL starve_lost%0d: got stall=%0b m_ready=%0b, want 0 0",
                 k, stall_pipe, m_ready);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (stall_pipe !== 1'b1)
      $display("FAIL starve_stall_rise: got %0b, want 1", stall_pipe);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    do_reset();
    starve_m();
    p_wen = 1'b0;
    #1;
    total_cnt++;
    if (m_ready !== 1'b1)
      $display("FAIL starve_m_ready: got %0b, want 1", m_ready);
    else pass_cnt++;
    step();
    m_valid = 1'b0;
    total_cnt++;
    if (stall_pipe !== 1'b0 || rf_wen !== 1'b1 || rf_waddr !== 5'd9 || proto_err !== 1'b0)
      $display("FAIL starve_release: got stall=%0b wen=%0b addr=%0d err=%0b, want 0 1 9 0",
               stall_pipe, rf_wen, rf_waddr, proto_err);
    else pass_cnt++;
  endtask

  task automatic test_proto_err();
    do_reset();
    starve_m();
    p_waddr = 5'd6; p_wdata = 64'h66;
    step();
    total_cnt++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 64'h66 || proto_err !== 1'b1)
      $display("FAIL proto_write: got wen=%0b addr=%0d data=%0h err=%0b, want 1 6 66 1",
               rf_wen, rf_waddr, rf_wdata, proto_err);
    else pass_cnt++;
    idle_inputs();
    step();
    step();
    total_cnt++;
    if (proto_err !== 1'b1 || stall_pipe !== 1'b0)
      $display("FAIL proto_sticky: got err=%0b stall=%0b, want 1 0", proto_err, stall_pipe);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (proto_err !== 1'b0)
      $display("FAIL proto_clear: got %0b, want 0", proto_err);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_x0_drop();
    do_reset();
    l_valid = 1'b1; l_waddr = 5'd0; l_wdata = 64'h55;
    #1;
    total_cnt++;
    if (l_ready !== 1'b1)
      $display("FAIL x0_ready: got %0b, want 1", l_ready);
    else pass_cnt++;
    step();
    l_valid = 1'b0;
    m_valid = 1'b1; m_waddr = 5'd7; m_wdata = 64'h77;
    total_cnt++;
    if (rf_wen !== 1'b0)
      $display("FAIL x0_drop: got wen=%0b, want 0", rf_wen);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (m_ready !== 1'b1)
      $display("FAIL x0_next_ready: got %0b, want 1", m_ready);
    else pass_cnt++;
    step();
    idle_inputs();
    total_cnt++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'h77)
      $display("FAIL x0_next_write: got wen=%0b addr=%0d data=%0h, want 1 7 77",
               rf_wen, rf_waddr, rf_wdata);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    starve_m();
    step();  // pipeline keeps writing while stalled
    m_valid = 1'b1; l_valid = 1'b1; p_wen = 1'b0;
    m_waddr = 5'd12; l_waddr = 5'd13;
    total_cnt++;
    if (stall_pipe !== 1'b1 || rf_wen !== 1'b1)
      $display("FAIL arst_pre: got stall=%0b wen=%0b, want 1 1", stall_pipe, rf_wen);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({rf_wen, rf_waddr, rf_wdata, stall_pipe, proto_err, m_ready, l_ready} !== '0)
      $display("FAIL arst_clear: got wen=%0b addr=%0d stall=%0b err=%0b mr=%0b lr=%0b, want 0",
               rf_wen, rf_waddr, stall_pipe, proto_err, m_ready, l_ready);
    else pass_cnt++;
    step();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (m_ready !== 1'b1 || l_ready !== 1'b0)
      $display("FAIL arst_first_grant: got m=%0b l=%0b, want 1 0", m_ready, l_ready);
    else pass_cnt++;
    step();
    idle_inputs();
    total_cnt++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd12)
      $display("FAIL arst_first_write: got wen=%0b addr=%0d, want 1 12", rf_wen, rf_waddr);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_pipeline();
    test_round_robin();
    test_starvation();
    test_proto_err();
    test_x0_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
